// File: rtl/mul_control_if.sv
// Control/status bundle between mul_control and the multiplier datapath/top level.
// With MUL_BUSY_ERR_EN defined the bundle also carries the sticky err flag.
interface mul_control_if;
    logic       run;
    logic       lsb;
    logic       w_ctrl;
    logic       addu_ctrl;
    logic       srl_ctrl;
    logic       busy;
    logic       ready;
    logic       done;
    // Debug view of the sequencer state: 0 IDLE, 1 LOAD, 2 CALC, 3 DONE
    logic [1:0] state;
`ifdef MUL_BUSY_ERR_EN
    logic       err;

    modport master (
        input  run, lsb,
        output w_ctrl, addu_ctrl, srl_ctrl, busy, ready, done, state, err
    );
    modport slave (
        output run, lsb,
        input  w_ctrl, addu_ctrl, srl_ctrl, busy, ready, done, state, err
    );
`else
    modport master (
        input  run, lsb,
        output w_ctrl, addu_ctrl, srl_ctrl, busy, ready, done, state
    );
    modport slave (
        output run, lsb,
        input  w_ctrl, addu_ctrl, srl_ctrl, busy, ready, done, state
    );
`endif
endinterface

// File: rtl/mul_control.sv
// Shift-add unsigned multiplier sequencer: IDLE -> LOAD -> CALC (WIDTH cycles) -> DONE.
// Optional MUL_BUSY_ERR_EN adds a sticky err flag for run edges that arrive while busy.
//
// Handshake: an operation starts on a rising edge of bus.run seen in IDLE. Edges seen
// in LOAD/CALC/DONE are dropped, not queued. bus.ready rises on the edge that ends DONE
// and stays high until the next accepted start; bus.done pulses for the DONE cycle.
module mul_control #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_control_if.master bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q;
    logic             ready_q, ready_d;
    logic             start;

    logic             w_ctrl;
    logic             addu_ctrl;
    logic             srl_ctrl;
    logic             busy;
    logic             done;

    assign start = bus.run & ~run_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= bus.run;
            ready_q <= ready_d;
        end
    end

    // Strobes are decoded from the current state (and lsb in CALC) so the datapath
    // acts on them in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        w_ctrl    = 1'b0;
        addu_ctrl = 1'b0;
        srl_ctrl  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ready_d = 1'b0;
                end
            end
            LOAD: begin
                w_ctrl  = 1'b1;
                busy    = 1'b1;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                busy      = 1'b1;
                srl_ctrl  = 1'b1;
                addu_ctrl = bus.lsb;
                // Counter holds on the last iteration so it never wraps.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MUL_BUSY_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = (state_q != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.w_ctrl    = w_ctrl;
    assign bus.addu_ctrl = addu_ctrl;
    assign bus.srl_ctrl  = srl_ctrl;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ready     = ready_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mul_control.sv
// Directed bench for mul_control: WIDTH=4 sequencing cases plus a WIDTH=32 run
// against a shift-add datapath model.
module tb_mul_control;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_control_if if4 ();
    mul_control_if if32 ();

    mul_control #(.WIDTH(4)) u4 (
        .clk  (clk),
        .reset(reset),
        .bus  (if4.master)
    );

    mul_control #(.WIDTH(32)) u32 (
        .clk  (clk),
        .reset(reset),
        .bus  (if32.master)
    );

    int checks = 0;
    int errors = 0;

    // Shift-add datapath model for the WIDTH=32 instance
    logic [31:0] a_op, b_op;
    logic [31:0] hi, lo, mc;
    logic [32:0] sum_w;
    int          srl_seen = 0;

    assign sum_w    = {1'b0, hi} + (if32.addu_ctrl ? {1'b0, mc} : 33'd0);
    assign if32.lsb = lo[0];

    always @(posedge clk) begin
        if (if32.w_ctrl) begin
            hi <= 32'd0;
            lo <= b_op;
            mc <= a_op;
        end else if (if32.srl_ctrl) begin
            hi       <= sum_w[32:1];
            lo       <= {sum_w[0], lo[31:1]};
            srl_seen <= srl_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic w, input logic a, input logic s,
                            input logic b, input logic r, input logic d);
        chk({tag, ".w_ctrl"},    64'(if4.w_ctrl),    64'(w));
        chk({tag, ".addu_ctrl"}, 64'(if4.addu_ctrl), 64'(a));
        chk({tag, ".srl_ctrl"},  64'(if4.srl_ctrl),  64'(s));
        chk({tag, ".busy"},      64'(if4.busy),      64'(b));
        chk({tag, ".ready"},     64'(if4.ready),     64'(r));
        chk({tag, ".done"},      64'(if4.done),      64'(d));
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    logic [3:0] pat;
    int         done_cnt;
    logic       got_ready;

    initial begin
        reset     = 1'b1;
        if4.run   = 1'b0;
        if4.lsb   = 1'b0;
        if32.run  = 1'b0;
        a_op      = 32'd0;
        b_op      = 32'd0;

        // 1: reset for two cycles
        next_cycle();
        next_cycle();
        #1;
        chk_outs("rst", 0, 0, 0, 0, 0, 0);
        chk("rst.state", 64'(if4.state), 64'd0);
`ifdef MUL_BUSY_ERR_EN
        chk("rst.err", 64'(if4.err), 64'd0);
`endif

        // 2: run rises and stays high, lsb pattern 1,0,1,1
        reset = 1'b0;
        next_cycle();
        if4.run = 1'b1;
        #1;
        chk_outs("t2_idle", 0, 0, 0, 0, 0, 0);
        next_cycle();
        #1;
        chk_outs("t2_load", 1, 0, 0, 1, 0, 0);
        chk("t2_load.state", 64'(if4.state), 64'd1);
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if4.lsb = pat[i];
            #1;
            chk_outs($sformatf("t2_calc%0d", i), 0, pat[i], 1, 1, 0, 0);
        end
        next_cycle();
        if4.lsb = 1'b0;
        #1;
        chk_outs("t2_done", 0, 0, 0, 0, 0, 1);
        chk("t2_done.state", 64'(if4.state), 64'd3);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk_outs($sformatf("t2_hold%0d", i), 0, 0, 0, 0, 1, 0);
            chk($sformatf("t2_hold%0d.state", i), 64'(if4.state), 64'd0);
        end

        // 3: second run edge mid-CALC is ignored
        next_cycle();
        if4.run = 1'b0;
        next_cycle();
        if4.run = 1'b1;
        next_cycle();
        #1;
        chk_outs("t3_load", 1, 0, 0, 1, 0, 0);
        next_cycle();
        if4.run = 1'b0;
        #1;
        chk_outs("t3_calc0", 0, 0, 1, 1, 0, 0);
        next_cycle();
        if4.run = 1'b1;
        #1;
        chk_outs("t3_calc1", 0, 0, 1, 1, 0, 0);
        next_cycle();
        #1;
        chk_outs("t3_calc2", 0, 0, 1, 1, 0, 0);
`ifdef MUL_BUSY_ERR_EN
        chk("t3_calc2.err", 64'(if4.err), 64'd1);
`endif
        next_cycle();
        #1;
        chk_outs("t3_calc3", 0, 0, 1, 1, 0, 0);
        next_cycle();
        #1;
        chk_outs("t3_done", 0, 0, 0, 0, 0, 1);
        next_cycle();
        #1;
        chk_outs("t3_idle", 0, 0, 0, 0, 1, 0);
`ifdef MUL_BUSY_ERR_EN
        chk("t3_idle.err", 64'(if4.err), 64'd1);
`endif

        // 4: reset in the second CALC cycle, then a full fresh operation
        if4.run = 1'b0;
        next_cycle();
        if4.run = 1'b1;
        next_cycle();
        #1;
        chk_outs("t4_load", 1, 0, 0, 1, 0, 0);
`ifdef MUL_BUSY_ERR_EN
        chk("t4_load.err", 64'(if4.err), 64'd0);
`endif
        next_cycle();
        #1;
        chk_outs("t4_calc0", 0, 0, 1, 1, 0, 0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk_outs("t4_calc1", 0, 0, 1, 1, 0, 0);
        next_cycle();
        reset   = 1'b0;
        if4.run = 1'b0;
        #1;
        chk_outs("t4_abort", 0, 0, 0, 0, 0, 0);
        chk("t4_abort.state", 64'(if4.state), 64'd0);
        next_cycle();
        if4.run = 1'b1;
        next_cycle();
        #1;
        chk_outs("t4_reload", 1, 0, 0, 1, 0, 0);
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if4.lsb = pat[i];
            #1;
            chk_outs($sformatf("t4_calc%0d", i), 0, pat[i], 1, 1, 0, 0);
        end
        next_cycle();
        if4.lsb = 1'b0;
        #1;
        chk_outs("t4_done", 0, 0, 0, 0, 0, 1);
        next_cycle();
        #1;
        chk_outs("t4_ready", 0, 0, 0, 0, 1, 0);

        // 5: run edge coincident with reset is dropped
        if4.run = 1'b0;
        next_cycle();
        reset   = 1'b1;
        if4.run = 1'b1;
        next_cycle();
        reset   = 1'b0;
        if4.run = 1'b0;
        #1;
        chk_outs("t5_rst", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            chk_outs($sformatf("t5_idle%0d", i), 0, 0, 0, 0, 0, 0);
            chk($sformatf("t5_idle%0d.state", i), 64'(if4.state), 64'd0);
        end

        // 6: WIDTH=32, all-ones squared through the datapath model
        done_cnt  = 0;
        got_ready = 1'b0;
        next_cycle();
        a_op     = 32'hFFFF_FFFF;
        b_op     = 32'hFFFF_FFFF;
        if32.run = 1'b1;
        for (int i = 0; i < 100 && !got_ready; i++) begin
            next_cycle();
            #1;
            if (if32.done) done_cnt++;
            got_ready = if32.ready;
        end
        chk("t6_ready_timeout", 64'(got_ready), 64'd1);
        chk("t6_product", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("t6_srl_cycles", 64'(srl_seen), 64'd32);
        chk("t6_done_pulses", 64'(done_cnt), 64'd1);
        if32.run = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
